// File: rtl/result_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_bank: collects the three rows of product C, then streams its nine  |
// | elements row-major over valid/ready. Optional: RESULT_BANK_SAT_EN.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module result_bank #(
  parameter int ACC_W = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             flush,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic [ACC_W-1:0] row_c0,
  input  logic [ACC_W-1:0] row_c1,
  input  logic [ACC_W-1:0] row_c2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             overflow
);

  localparam logic [1:0] c_st_fill  = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [1:0] c_last_row = 2'd2;
  localparam logic [3:0] c_last_idx = 4'd8;

  logic [1:0]       r_state;
  logic [1:0]       r_wr_row;
  logic [3:0]       r_rd_idx;
  logic [ACC_W-1:0] r_c_mem [0:8];
  logic             r_overflow;

  logic             w_row_fire;
  logic             w_out_fire;
  logic [ACC_W-1:0] w_rd_val;
  logic             w_hi_nz;
  logic [OUT_W-1:0] w_conv;

  // Handshake flags decode registered state only, never the partner's strobe.
  assign row_ready  = (r_state == c_st_fill);
  assign out_valid  = (r_state == c_st_drain);
  assign done       = (r_state == c_st_done);
  assign out_last   = out_valid && (r_rd_idx == c_last_idx);
  assign overflow   = r_overflow;

  assign w_row_fire = row_ready && row_valid;
  assign w_out_fire = out_valid && out_ready;

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < 9; i++) begin
      if (r_rd_idx == 4'(i)) begin
        w_rd_val = r_c_mem[i];
      end
    end
  end

  generate
    if (OUT_W < ACC_W) begin : g_hi_bits
      assign w_hi_nz = |w_rd_val[ACC_W-1:OUT_W];
    end else begin : g_no_hi_bits
      assign w_hi_nz = 1'b0;
    end
  endgenerate

`ifdef RESULT_BANK_SAT_EN
  // Any set bit above OUT_W means the value exceeds the output range.
  assign w_conv = w_hi_nz ? {OUT_W{1'b1}} : w_rd_val[OUT_W-1:0];
`else
  assign w_conv = w_rd_val[OUT_W-1:0];
`endif

  assign out_data = out_valid ? w_conv : '0;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= c_st_fill;
      r_wr_row <= 2'd0;
      r_rd_idx <= 4'd0;
    end else if (flush) begin
      r_state  <= c_st_fill;
      r_wr_row <= 2'd0;
      r_rd_idx <= 4'd0;
    end else begin
      case (r_state)
        c_st_fill: begin
          if (row_valid) begin
            if (r_wr_row == c_last_row) begin
              r_state  <= c_st_drain;
              r_wr_row <= 2'd0;
              r_rd_idx <= 4'd0;
            end else begin
              r_wr_row <= r_wr_row + 2'd1;
            end
          end
        end
        c_st_drain: begin
          if (out_ready) begin
            if (r_rd_idx == c_last_idx) begin
              r_state  <= c_st_done;
              r_rd_idx <= 4'd0;
            end else begin
              r_rd_idx <= r_rd_idx + 4'd1;
            end
          end
        end
        c_st_done: r_state <= c_st_fill;
        default:   r_state <= c_st_fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 9; i++) r_c_mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 9; i++) r_c_mem[i] <= '0;
    end else if (w_row_fire) begin
      case (r_wr_row)
        2'd0: begin
          r_c_mem[0] <= row_c0;
          r_c_mem[1] <= row_c1;
          r_c_mem[2] <= row_c2;
        end
        2'd1: begin
          r_c_mem[3] <= row_c0;
          r_c_mem[4] <= row_c1;
          r_c_mem[5] <= row_c2;
        end
        default: begin
          r_c_mem[6] <= row_c0;
          r_c_mem[7] <= row_c1;
          r_c_mem[8] <= row_c2;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_out_fire && w_hi_nz) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_bank.sv
`default_nettype none
// Directed bench for result_bank: scoreboard of expected elements, checked
// with immediate assertions as each element transfers.
module tb_result_bank;
  localparam int ACC_W = 10;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             clear_n;
  logic             flush;
  logic             row_valid;
  logic             row_ready;
  logic [ACC_W-1:0] row_c0, row_c1, row_c2;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             done;
  logic             overflow;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_ovf;
  int   cyc;

  always #5 clk = ~clk;

  result_bank #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .clear_n(clear_n), .flush(flush),
    .row_valid(row_valid), .row_ready(row_ready),
    .row_c0(row_c0), .row_c1(row_c1), .row_c2(row_c2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] v);
`ifdef RESULT_BANK_SAT_EN
    return (v > 10'd255) ? 8'hFF : v[OUT_W-1:0];
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  task automatic push_row(input logic [ACC_W-1:0] a, b, c, input int r);
    logic [ACC_W-1:0] v [3];
    exp_t e;
    v[0] = a; v[1] = b; v[2] = c;
    for (int k = 0; k < 3; k++) begin
      e.data = conv(v[k]);
      e.last = (r == 2) && (k == 2);
      e.ovf  = (v[k] > 10'd255);
      sb.push_back(e);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance + gap.
  task automatic send_row(input logic [ACC_W-1:0] a, b, c, input int r, input int gap);
    int t = 0;
    row_valid = 1'b1;
    row_c0 = a; row_c1 = b; row_c2 = c;
    while (!row_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!row_ready) check("row_accept_timeout", row_ready, 1);
    push_row(a, b, c, r);
    @(negedge clk);
    row_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_matrix(input logic [ACC_W-1:0] base);
    send_row(base,            base + 10'd1, base + 10'd2, 0, 0);
    send_row(base + 10'd3,    base + 10'd4, base + 10'd5, 1, 0);
    send_row(base + 10'd6,    base + 10'd7, base + 10'd8, 2, 0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode, input int n, output int cycles);
    int   got = 0;
    int   c = 0;
    logic stalled = 1'b0;
    logic [OUT_W-1:0] held = '0;
    exp_t e;
    while (got < n && c < 200) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      check("out_valid", out_valid, 1);
      check("row_ready_in_drain", row_ready, 0);
      check("overflow_sticky", overflow, exp_ovf);
      if (stalled) check("held_data", out_data, held);
      if (out_ready) begin
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          exp_ovf = exp_ovf | e.ovf;
        end
        got++;
        stalled = 1'b0;
      end else begin
        held    = out_data;
        stalled = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b0;
    check("drain_count", got, n);
    cycles = c;
  endtask

  task automatic finish_checks();
    check("done_pulse", done, 1);
    check("done_out_valid", out_valid, 0);
    check("done_row_ready", row_ready, 0);
    check("done_overflow", overflow, exp_ovf);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("refill_row_ready", row_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_n = 1'b0; flush = 1'b0; row_valid = 1'b0; out_ready = 1'b0;
    row_c0 = '0; row_c1 = '0; row_c2 = '0;
    exp_ovf = 1'b0;
    #1;
    check("rst_row_ready", row_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);

    // Basic: back-to-back rows, out_ready high, one-cycle latency.
    send_matrix(10'd1);
    check("first_elem_latency", out_valid, 1);
    drain(0, 9, cyc);
    check("drain_cycles", cyc, 9);
    finish_checks();

    // Backpressure.
    send_matrix(10'd1);
    drain(1, 9, cyc);
    finish_checks();

    // Input stall, then a row held high through DRAIN.
    send_row(10'd10, 10'd20, 10'd30, 0, 2);
    send_row(10'd40, 10'd50, 10'd60, 1, 2);
    send_row(10'd70, 10'd80, 10'd90, 2, 0);
    row_valid = 1'b1;
    row_c0 = 10'd15; row_c1 = 10'd15; row_c2 = 10'd15;
    drain(0, 9, cyc);
    finish_checks();
    push_row(10'd15, 10'd15, 10'd15, 0);
    @(negedge clk);
    row_valid = 1'b0;
    check("after_held_row_ready", row_ready, 1);
    send_row(10'd1, 10'd1, 10'd1, 1, 0);
    send_row(10'd2, 10'd2, 10'd2, 2, 0);
    drain(0, 9, cyc);
    finish_checks();

    // Overflow: C[1][1] = 300, sticky across the following matrix.
    send_row(10'd0, 10'd1,   10'd2, 0, 0);
    send_row(10'd3, 10'd300, 10'd5, 1, 0);
    send_row(10'd6, 10'd7,   10'd8, 2, 0);
    drain(0, 9, cyc);
    finish_checks();
    check("overflow_held", overflow, 1);
    send_matrix(10'd20);
    drain(0, 9, cyc);
    finish_checks();

    // Asynchronous abort mid-DRAIN at rd_idx = 4.
    send_matrix(10'd1);
    drain(0, 4, cyc);
    clear_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_row_ready", row_ready, 1);
    check("abort_out_data", out_data, 0);
    check("abort_overflow", overflow, 0);
    sb.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    send_matrix(10'd11);
    drain(0, 9, cyc);
    finish_checks();

    // Synchronous flush mid-DRAIN beats a same-cycle transfer.
    send_row(10'd1,   10'd2, 10'd3, 0, 0);
    send_row(10'd400, 10'd5, 10'd6, 1, 0);
    send_row(10'd7,   10'd8, 10'd9, 2, 0);
    drain(0, 4, cyc);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    check("flush_pre_out_valid", out_valid, 1);
    check("flush_pre_overflow", overflow, 1);
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_row_ready", row_ready, 1);
    check("flush_out_data", out_data, 0);
    check("flush_overflow", overflow, 0);
    sb.delete();
    exp_ovf = 1'b0;
    // A row offered together with flush must be dropped.
    flush = 1'b1;
    row_valid = 1'b1;
    row_c0 = 10'd99; row_c1 = 10'd99; row_c2 = 10'd99;
    @(negedge clk);
    flush = 1'b0;
    row_valid = 1'b0;
    send_matrix(10'd21);
    drain(0, 9, cyc);
    finish_checks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_bank.md
# result_bank

Result-side storage for the 3x3 matrix multiplier. It accepts the three rows of the product matrix C, one row per handshake beat, as the multiplier array finishes them. Once all three rows are held, it streams the nine elements out serially in row-major order over a valid/ready interface. It is the drain end of the datapath, mirroring the serial load of the input matrices into the memory bank.

## Interface
Parameters:
- ACC_W, 10, width of each incoming C element; 3 products of 4b x 4b need 8+2 bits.
- OUT_W, 8, width of each serialized output element; must be ≤ ACC_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clear_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous abort; discards stored rows and returns to FILL.
- row_valid  input  1  row_c0..2 carry a valid row of C.
- row_ready  output  1  block can accept a row this cycle.
- row_c0, row_c1, row_c2  input  ACC_W each  C[r][0], C[r][1], C[r][2] of the current row r.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  OUT_W  current element C[i][j].
- out_last  output  1  high with the element C[2][2].
- done  output  1  one-cycle pulse after the final element transfers.
- overflow  output  1  sticky; at least one streamed element exceeded OUT_W bits since the last reset or flush.

## Operation
- Storage is nine ACC_W registers, c_mem[0..8], at index 3*r+c.
- FSM states and transitions:
  - FILL: row_ready=1, out_valid=0. When row_valid, the row is written to c_mem[3*wr_row..3*wr_row+2] and wr_row increments. Accepting row 2 moves the FSM to DRAIN with rd_idx=0 and wr_row=0.
  - DRAIN: row_ready=0, so row_valid is ignored and not accepted. out_valid=1 and out_data=conv(c_mem[rd_idx]).
    - When out_ready, rd_idx increments.
    - When out_ready at rd_idx=8, the FSM moves to DONE.
    - out_data and out_valid are held stable while out_ready=0.
  - DONE: lasts one cycle. done=1, out_valid=0, row_ready=0. The FSM then returns to FILL.
- out_last = (state==DRAIN) && rd_idx==8.
- conv(v) without the macro: v[OUT_W-1:0], plain truncation.
- overflow is set when a transfer occurs (out_valid && out_ready) and v[ACC_W-1:OUT_W] is nonzero.
- Reset (clear_n low) clears immediately, at any point including mid-DRAIN:
  - state=FILL, wr_row=0, rd_idx=0, all c_mem=0.
  - Outputs: row_ready=1, out_valid=0, out_data=0, out_last=0, done=0, overflow=0.
- flush=1 has the same effect as reset, but is synchronous. It has priority over any handshake in the same cycle; a row or element presented that cycle is not transferred.

## Timing
- row_ready and out_valid are combinational decodes of the registered state only. Neither depends on row_valid or out_ready.
- Row accepted on edge k while wr_row=2 → out_valid=1 from cycle k+1. Latency from third row accept to first element is 1 cycle.
- With out_ready tied high, the 9 elements occupy 9 consecutive cycles, done pulses on the 10th, and row_ready is 1 again on the 11th.
- A full matrix therefore takes a minimum of 3 + 9 + 1 = 13 cycles.
- The upstream producer must hold row_valid and the row data stable until row_ready is seen. The block captures exactly one row per cycle in which both are high.

## Configuration
- RESULT_BANK_SAT_EN defined: conv(v) saturates. If v > 2^OUT_W−1, out_data = 2^OUT_W−1; otherwise out_data = v. The overflow flag behaves identically.
- Not defined: conv is plain truncation as described above.
- If OUT_W == ACC_W, both modes are identical and overflow stays 0.

## Test plan
- Basic: rows {1,2,3},{4,5,6},{7,8,9} with out_ready=1 → out_data 1..9 on consecutive cycles, out_last with 9, done one cycle later, overflow=0.
- Backpressure: toggle out_ready 1,0,0,1,… → each element held unchanged while out_ready=0, no element skipped or duplicated, order 1..9 preserved.
- Input stall: row_valid pulsed with 2-cycle gaps, then row_valid held high during DRAIN with row {15,15,15} → rows 0–2 stored correctly, the DRAIN-time row not accepted, and it is taken as row 0 of the next matrix after done.
- Overflow: C[1][1]=300, OUT_W=8 → out_data=44 (300 mod 256) with the macro absent, 255 with RESULT_BANK_SAT_EN; overflow=1 from the cycle after that transfer until reset.
- Abort: clear_n pulsed low mid-DRAIN at rd_idx=4 → out_valid=0 and row_ready=1 immediately; the next matrix streams from C[0][0]. Repeat using flush and confirm the same result one edge later.
